// File: rtl/vec_pkg.sv
// vec_pkg: shared definitions for the vector result-path blocks.
//   vos_state_t : serializer state encoding (IDLE, STREAM, DONE)
//   VLEN_W(n)   : width of a length/index able to hold 0..n inclusive
package vec_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } vos_state_t;

   function automatic int VLEN_W(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/vec_snapshot_reg.sv
// vec_snapshot_reg: load-enabled N-entry array register.
//   clk, rst_n : clock, asynchronous active-low clear (all entries to 0)
//   load       : capture d into q on the rising edge
//   d          : N x BITS input array
//   q          : N x BITS registered array
module vec_snapshot_reg #(
   parameter int BITS = 8,
   parameter int N    = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [BITS-1:0] d [N],
   output logic [BITS-1:0] q [N]
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N; i++) q[i] <= '0;
      end else if (load) begin
         for (int unsigned i = 0; i < N; i++) q[i] <= d[i];
      end
   end

endmodule

// File: rtl/vec_out_stream.sv
// vec_out_stream: snapshots a result vector on start and streams its first
// len elements LANES at a time over a valid/ready interface.
//   clk, rst_n : clock, asynchronous active-low reset
//   in, in_len : vector and active length, sampled only on accepted start
//   start      : begin a transfer (honoured only in IDLE)
//   abort      : end the current transfer; done still pulses
//   out_data   : LANES x BITS beat payload (masked lanes read 0)
//   out_keep   : per-lane valid mask
//   out_last   : final beat of the vector
//   out_valid  : beat present
//   out_ready  : sink accepts the beat
//   busy       : not IDLE
//   done       : one-cycle completion pulse
// All outputs decode registered state only; out_ready steers idx/state.
module vec_out_stream
   import vec_pkg::*;
#(
   parameter int BITS  = 8,
   parameter int N     = 64,
   parameter int LANES = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [BITS-1:0]        in [N],
   input  logic [VLEN_W(N)-1:0]   in_len,
   input  logic                   start,
   input  logic                   abort,
   output logic [BITS-1:0]        out_data [LANES],
   output logic [LANES-1:0]       out_keep,
   output logic                   out_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done
);

   localparam int LW = VLEN_W(N);
   localparam int IW = $clog2(N);

   vos_state_t      state, state_nxt;
   logic [LW-1:0]   idx, len, len_clamp;
   logic [BITS-1:0] snap [N];
   logic            load;
   logic            xfer;

   assign len_clamp = (in_len > LW'(N)) ? LW'(N) : in_len;
   assign load      = (state == IDLE) && start;
   assign xfer      = out_valid && out_ready;

   vec_snapshot_reg #(
      .BITS (BITS),
      .N    (N)
   ) u_snap (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .d     (in),
      .q     (snap)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; abort wins over a concurrent transfer
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = (len_clamp == '0) ? DONE : STREAM;
         end
         STREAM: begin
            if (abort)                     state_nxt = DONE;
            else if (xfer && out_last)     state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Length and element index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         len <= '0;
      end else if (load) begin
         idx <= '0;
         len <= len_clamp;
      end else if ((state == STREAM) && !abort && xfer) begin
         idx <= idx + LW'(LANES);
      end
   end

   // Output decode
   always_comb begin
      out_valid = (state == STREAM);
      busy      = (state != IDLE);
      done      = (state == DONE);
      out_last  = (state == STREAM) &&
                  (({1'b0, idx} + (LW+1)'(LANES)) >= {1'b0, len});
   end

   // Lane mux: lane g carries element idx+g when it lies below len.
   // The snapshot index is only used when pos < len <= N, so the low
   // IW bits are always in range.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [LW:0] pos;
      always_comb begin
         pos         = {1'b0, idx} + (LW+1)'(g);
         out_keep[g] = (state == STREAM) && (pos < {1'b0, len});
         out_data[g] = out_keep[g] ? snap[pos[IW-1:0]] : '0;
      end
   end

endmodule

// File: tb/tb_vec_out_stream.sv
module tb_vec_out_stream;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] vin [8];
   logic [3:0] in_len;
   logic       start, abort, out_ready;
   logic [7:0] out_data [2];
   logic [1:0] out_keep;
   logic       out_last, out_valid, busy, done;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   always #5 clk = ~clk;

   vec_out_stream #(
      .BITS  (8),
      .N     (8),
      .LANES (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (vin),
      .in_len    (in_len),
      .start     (start),
      .abort     (abort),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_beat(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [1:0] keep, input logic last);
      chk({tag, ".valid"}, out_valid, 1'b1);
      chk({tag, ".d0"}, out_data[0], d0);
      chk({tag, ".d1"}, out_data[1], d1);
      chk({tag, ".keep"}, out_keep, keep);
      chk({tag, ".last"}, out_last, last);
   endtask

   task automatic chk_quiet(input string tag, input logic exp_done, input logic exp_busy);
      chk({tag, ".valid"}, out_valid, 1'b0);
      chk({tag, ".d0"}, out_data[0], 8'h00);
      chk({tag, ".d1"}, out_data[1], 8'h00);
      chk({tag, ".keep"}, out_keep, 2'b00);
      chk({tag, ".last"}, out_last, 1'b0);
      chk({tag, ".done"}, done, exp_done);
      chk({tag, ".busy"}, busy, exp_busy);
   endtask

   task automatic load_ramp();
      for (int k = 0; k < 8; k++) vin[k] = 8'h10 + 8'(k);
   endtask

   initial begin
      int b;
      logic rdy;
      logic [3:0] pat;

      rst_n = 1'b0; start = 0; abort = 0; out_ready = 0; in_len = '0;
      load_ramp();
      #1;
      chk_quiet("reset", 1'b0, 1'b0);
      #10 rst_n = 1'b1;
      step();
      chk_quiet("idle", 1'b0, 1'b0);

      // len 5, ready held high
      in_len = 4'd5; out_ready = 1; start = 1;
      step(); start = 0;
      chk("s1.busy", busy, 1'b1);
      chk_beat("s1.b0", 8'h10, 8'h11, 2'b11, 1'b0);
      step();
      chk_beat("s1.b1", 8'h12, 8'h13, 2'b11, 1'b0);
      step();
      chk_beat("s1.b2", 8'h14, 8'h00, 2'b01, 1'b1);
      step();
      chk_quiet("s1.done", 1'b1, 1'b1);
      step();
      chk_quiet("s1.idle", 1'b0, 1'b0);

      // len 8, ready pattern 1,0,0,1 repeating
      in_len = 4'd8; start = 1; out_ready = 0;
      step(); start = 0;
      pat = 4'b1001;
      b = 0;
      for (int c = 0; c < 20 && b < 4; c++) begin
         chk_beat($sformatf("s2.c%0d", c), 8'h10 + 8'(2*b), 8'h11 + 8'(2*b), 2'b11, b == 3);
         rdy = pat[3 - (c % 4)];
         out_ready = rdy;
         step();
         if (rdy) b++;
      end
      chk("s2.beats", 32'(b), 32'd4);
      chk_quiet("s2.done", 1'b1, 1'b1);
      out_ready = 1;
      step();
      chk_quiet("s2.idle", 1'b0, 1'b0);

      // len 0: done one cycle after start, no beat
      in_len = 4'd0; start = 1;
      step(); start = 0;
      chk_quiet("s3.done", 1'b1, 1'b1);
      step();
      chk_quiet("s3.idle", 1'b0, 1'b0);

      // len 12 clamped to 8; mid-stream start ignored
      in_len = 4'd12; start = 1;
      step(); start = 0;
      chk_beat("s4.b0", 8'h10, 8'h11, 2'b11, 1'b0);
      for (int k = 0; k < 8; k++) vin[k] = 8'hA0 + 8'(k);
      in_len = 4'd3; start = 1;
      step(); start = 0;
      chk_beat("s4.b1", 8'h12, 8'h13, 2'b11, 1'b0);
      step();
      chk_beat("s4.b2", 8'h14, 8'h15, 2'b11, 1'b0);
      step();
      chk_beat("s4.b3", 8'h16, 8'h17, 2'b11, 1'b1);
      step();
      chk_quiet("s4.done", 1'b1, 1'b1);
      load_ramp();
      step();
      chk_quiet("s4.idle", 1'b0, 1'b0);

      // abort after the first beat transfers
      in_len = 4'd8; start = 1;
      step(); start = 0;
      chk_beat("s5.b0", 8'h10, 8'h11, 2'b11, 1'b0);
      step();
      chk_beat("s5.b1", 8'h12, 8'h13, 2'b11, 1'b0);
      abort = 1;
      step(); abort = 0;
      chk_quiet("s5.done", 1'b1, 1'b1);
      step();
      chk_quiet("s5.idle", 1'b0, 1'b0);
      in_len = 4'd2; start = 1;
      step(); start = 0;
      chk_beat("s5.n0", 8'h10, 8'h11, 2'b11, 1'b1);
      step();
      chk_quiet("s5.ndone", 1'b1, 1'b1);
      step();
      chk_quiet("s5.nidle", 1'b0, 1'b0);

      // async reset during the second beat
      in_len = 4'd8; start = 1;
      step(); start = 0;
      chk_beat("s6.b0", 8'h10, 8'h11, 2'b11, 1'b0);
      step();
      chk_beat("s6.b1", 8'h12, 8'h13, 2'b11, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_quiet("s6.rst", 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk_quiet("s6.post0", 1'b0, 1'b0);
      step();
      chk_quiet("s6.post1", 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
